rr_grant_ctrl: RTL
==================

# rr_grant_ctrl

Sequential round-robin grant controller that shares one resource between `WIDTH` requesters. Each cycle in which the resource is free, it selects one active request by rotating priority, registers a one-hot grant, and holds it until the owner drops its request or a hold-time limit expires. It then advances the priority base to the position just after the last owner. It sits between the requester ports and the shared resource's select/enable logic.

## Interface
- `WIDTH`, 4: number of requesters; valid range ≥ 2.
- `MAX_HOLD`, 8: maximum consecutive cycles one owner may hold the grant; 0 disables the limit. Range 0..65535.
- `IDW`, `$clog2(WIDTH)`: width of `grant_id`.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in WIDTH: request vector; bit i high = requester i wants the resource.
- `grant` out WIDTH: registered one-hot grant, or all-zero.
- `grant_valid` out 1: registered; equals `|grant`.
- `grant_id` out IDW: registered binary index of the set `grant` bit; 0 when `grant_valid` is 0.
- `timeout` out 1: registered one-cycle pulse on a forced release.
- `base` out WIDTH: registered one-hot priority base (debug/observation).

## Operation
- **State machine:** two states, IDLE and BUSY.
- **Reset values:**
  - State is IDLE.
  - `grant`, `grant_id`, `grant_valid` and `timeout` are all 0.
  - `base` is 1 (bit 0).
  - The hold counter is 0.
- **Selection function:** the pick is the first set bit of `req` at or above the `base` position, searching upward with wrap from bit WIDTH-1 to bit 0. If `req` is 0, there is no pick.
- **IDLE:**
  - If `req != 0`: load `grant` with the one-hot pick, set `grant_id`, clear the hold counter, and go to BUSY.
  - Otherwise stay in IDLE with `grant` = 0.
- **BUSY, normal release:** if `req[grant_id]` is 0, this is a release.
  - `grant` and `grant_id` go to 0 and the state goes to IDLE.
  - `base` is set to `grant` rotated left by 1 (bit WIDTH-1 wraps to bit 0).
- **BUSY, forced release:** if `MAX_HOLD != 0`, the hold counter equals MAX_HOLD-1, and `req[grant_id]` is still 1, this is a forced release.
  - Same updates as a normal release.
  - `timeout` is 1 for the next cycle.
- **BUSY, otherwise:** increment the hold counter and hold `grant` unchanged.
- **Simultaneous events:**
  - A request drop on the same cycle as counter expiry counts as a normal release; `timeout` stays 0.
  - Requests from other bits never preempt the current owner.
- **Base updates:** `base` changes only on a release or forced release; it is never updated in IDLE.
- **Forced-release owner:** the owner loses priority the same way as on a normal release. If it keeps requesting, it competes again from the new base.
- **Hold counter:** width is `$clog2(MAX_HOLD+1)` (minimum 1 bit). It is never compared when `MAX_HOLD` = 0.
- **Reset in BUSY:** synchronous reset in any state forces all reset values on the next edge. No release bookkeeping or `timeout` pulse is produced.

## Timing
- **Grant latency:** a request sampled at edge N in IDLE produces `grant` valid after edge N (visible in cycle N+1).
- **Release latency:** a release sampled at edge M clears `grant` after edge M.
- **Mandatory gap:** there is at least one IDLE cycle with `grant` = 0 between consecutive grants, so the resource sees a one-cycle gap.
- **Throughput:** a grant lasts at least 1 cycle and at most MAX_HOLD cycles when `MAX_HOLD != 0`.
- **Forced-release cycle:** `timeout` is high in exactly the same cycle that `grant` first reads 0.
- **Registered outputs:** all outputs are registered. There is no combinational path from `req` to any output.

## Test plan
- **Reset release:** hold `rst`=1 for 2 cycles with `req`=4'b1111, then release.
  - During reset: `grant`=0, `base`=0001.
  - One cycle after the first sampled edge: `grant`=0001, `grant_id`=0.
- **Full rotation:** `req`=1111 with each owner dropping its bit for one cycle after 2 grant cycles, then re-raising.
  - Grant order: 0001, 0010, 0100, 1000, 0001.
  - `grant` = 0 for exactly one cycle between each grant.
- **Wrap search:** after requester 1 releases (`base`=0100), apply `req`=0001.
  - Required: `grant`=0001, `grant_id`=0.
  - After that release, `base`=0010.
- **Timeout (MAX_HOLD=3):** `req`=0011 held constantly from reset.
  - `grant`=0001 for exactly 3 cycles.
  - Next cycle: `grant`=0 and `timeout`=1.
  - Then `grant`=0010 for 3 cycles.
  - Then `grant`=0001 again.
- **Simultaneous drop and expiry (MAX_HOLD=3):** requester 0 drops `req` on the 3rd grant cycle.
  - Required: `timeout` stays 0, `base`=0010.
- **Mid-operation reset:** assert `rst` in the 2nd BUSY cycle with `grant`=0100.
  - Next cycle: `grant`=0, `base`=0001, `timeout`=0.
  - After `rst` drops with `req`=0100: `grant`=0100.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// ---------------------------------------------------------------------------
// rr_grant_ctrl
//
// Round-robin grant controller sharing one resource among WIDTH requesters.
// When the resource is free it picks the first active request at or above the
// rotating priority base (wrapping), registers a one-hot grant, and holds it
// until the owner drops its request or the hold limit expires. On either kind
// of release the base moves to the position just after the last owner, and
// the resource always sees at least one idle cycle between grants.
//
// Parameters:
//   WIDTH    - number of requesters (>= 2)
//   MAX_HOLD - max consecutive grant cycles per owner; 0 disables the limit
//   IDW      - width of grant_id
//
// Ports:
//   clk         - clock, all state updates on rising edge
//   rst         - synchronous active-high reset
//   req         - request vector, bit i = requester i wants the resource
//   grant       - registered one-hot grant (or all zero)
//   grant_valid - registered, equals |grant
//   grant_id    - registered binary index of the grant bit, 0 when idle
//   timeout     - registered one-cycle pulse on a forced release
//   base        - registered one-hot priority base (observation)
// ---------------------------------------------------------------------------
module rr_grant_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic             timeout,
  output logic [WIDTH-1:0] base
);

  // Counter wide enough to hold MAX_HOLD-1; kept at one bit when unused.
  localparam int          CW          = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_LAST_I);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    hold_cnt;
  logic [IDW-1:0]   base_idx;
  logic [IDW-1:0]   pick_id;
  logic [WIDTH-1:0] pick;
  logic             pick_found;
  logic             hold_expired;
  logic             owner_req;

  // Rotating-priority search: walk WIDTH positions starting at the base
  // index, wrapping modulo WIDTH, and take the first active request.
  // NOTE: every variable written here gets a default before any condition,
  // otherwise synthesis infers a latch for the paths that leave it untouched.
  always_comb begin
    int             pos;
    logic [IDW-1:0] idx;
    base_idx   = '0;
    pick_id    = '0;
    pick       = '0;
    pick_found = 1'b0;
    pos        = 0;
    idx        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (base[i]) base_idx = IDW'(i);
    end
    for (int k = 0; k < WIDTH; k++) begin
      pos = (int'(base_idx) + k) % WIDTH;
      idx = IDW'(pos);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
        pick[idx]  = 1'b1;
      end
    end
  end

  assign owner_req    = req[grant_id];
  // The limit is only ever compared when it is enabled.
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // NOTE: state and outputs are updated with non-blocking assignments so all
  // registers sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      base        <= WIDTH'(1);
      hold_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant       <= pick;
            grant_valid <= 1'b1;
            grant_id    <= pick_id;
            hold_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req || hold_expired) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            state       <= IDLE;
            base        <= {grant[WIDTH-2:0], grant[WIDTH-1]};
            // A drop coinciding with expiry is an ordinary release, so the
            // pulse fires only when the owner is still requesting.
            timeout     <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
